// File: rtl/piso_ctrl_pkg.sv
// Shared state encodings and sizing helper for the PISO frame controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package piso_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Width needed to index n values; never below 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load shift register presenting its output-end bit on so.
// Latency: load/shift take effect at the next clock edge.
// Backpressure: none; the controller gates shift with the sink handshake.
module piso_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic             so
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= d;
        end else if (clear) begin
            shreg <= '0;
        end else if (shift) begin
            // Move toward the output end, zero-filling behind.
            if (LSB_FIRST)
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            else
                shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign so = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];

endmodule

// File: rtl/piso_frame_ctrl.sv
// Sequences load/shift of a PISO datapath into framed serial beats plus an idle gap.
// Latency: first bit appears the cycle after the word is accepted.
// Backpressure: ser_ready low freezes the beat; in_ready is low outside IDLE.
module piso_frame_ctrl
    import piso_ctrl_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit LSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             frame_start,
    output logic             frame_last,
    output logic             busy,
    input  logic             abort
);

    localparam int CW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [GW-1:0] gap_cnt;
    logic          accept;
    logic          beat;
    logic          abort_act;
    logic          so;

    assign in_ready  = (state == ST_IDLE);
    assign busy      = !in_ready;
    assign ser_valid = (state == ST_SHIFT);
    assign accept    = in_valid && in_ready;
    assign beat      = ser_valid && ser_ready;
    // Abort only matters mid-frame; in IDLE a same-cycle word is still taken.
    assign abort_act = abort && busy;

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (beat && !abort_act),
        .clear (abort_act),
        .d     (in_data),
        .so    (so)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
        end else if (abort_act) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (beat) begin
                        if (cnt == CNT_LAST) begin
                            cnt     <= '0;
                            gap_cnt <= '0;
                            state   <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ser_out     = ser_valid && so;
    assign frame_start = ser_valid && (cnt == '0);
    assign frame_last  = ser_valid && (cnt == CNT_LAST);

endmodule

// File: tb/tb_piso_frame_ctrl.sv
// Bench for piso_frame_ctrl: three configurations checked every cycle against a frame-level model.
module tb_piso_frame_ctrl;

    logic       clk;
    logic       rst_n;
    logic       iv    [3];
    logic [3:0] id    [3];
    logic       srdy  [3];
    logic       abt   [3];
    logic       rdy_w [3];
    logic       busy_w[3];
    logic       sv_w  [3];
    logic       so_w  [3];
    logic       fs_w  [3];
    logic       fl_w  [3];

    // Model: a frame is "active" with a beat index, or a gap with cycles remaining, else idle.
    bit         m_act [3];
    int         m_beat[3];
    int         m_gap [3];
    logic [3:0] m_word[3];

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    piso_frame_ctrl #(.WIDTH(4), .LSB_FIRST(1'b1), .GAP_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_data(id[0]), .in_ready(rdy_w[0]),
        .ser_out(so_w[0]), .ser_valid(sv_w[0]), .ser_ready(srdy[0]), .frame_start(fs_w[0]),
        .frame_last(fl_w[0]), .busy(busy_w[0]), .abort(abt[0]));

    piso_frame_ctrl #(.WIDTH(4), .LSB_FIRST(1'b0), .GAP_CYCLES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_data(id[1]), .in_ready(rdy_w[1]),
        .ser_out(so_w[1]), .ser_valid(sv_w[1]), .ser_ready(srdy[1]), .frame_start(fs_w[1]),
        .frame_last(fl_w[1]), .busy(busy_w[1]), .abort(abt[1]));

    piso_frame_ctrl #(.WIDTH(4), .LSB_FIRST(1'b1), .GAP_CYCLES(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_data(id[2]), .in_ready(rdy_w[2]),
        .ser_out(so_w[2]), .ser_valid(sv_w[2]), .ser_ready(srdy[2]), .frame_start(fs_w[2]),
        .frame_last(fl_w[2]), .busy(busy_w[2]), .abort(abt[2]));

    function automatic bit lsb_of(input int c);
        return (c != 1);
    endfunction

    function automatic int gap_of(input int c);
        return (c == 0) ? 1 : ((c == 1) ? 2 : 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] obs_of(input int c);
        return {rdy_w[c], busy_w[c], sv_w[c], so_w[c], fs_w[c], fl_w[c]};
    endfunction

    // Expected {in_ready, busy, ser_valid, ser_out, frame_start, frame_last}.
    function automatic logic [5:0] m_exp(input int c);
        logic b;
        if (m_act[c]) begin
            b = lsb_of(c) ? m_word[c][m_beat[c]] : m_word[c][3 - m_beat[c]];
            return {1'b0, 1'b1, 1'b1, b, m_beat[c] == 0, m_beat[c] == 3};
        end
        if (m_gap[c] > 0) return 6'b010000;
        return 6'b100000;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < 3; c++) begin
            m_act[c]  = 1'b0;
            m_beat[c] = 0;
            m_gap[c]  = 0;
            m_word[c] = 4'h0;
        end
    endtask

    task automatic m_step(input int c, input logic v, input logic [3:0] d,
                          input logic sr, input logic ab);
        if (!m_act[c] && m_gap[c] == 0) begin
            if (v) begin
                m_act[c]  = 1'b1;
                m_word[c] = d;
                m_beat[c] = 0;
            end
        end else if (ab) begin
            m_act[c] = 1'b0;
            m_gap[c] = 0;
        end else if (m_act[c]) begin
            if (sr) begin
                if (m_beat[c] == 3) begin
                    m_act[c] = 1'b0;
                    m_gap[c] = gap_of(c);
                end else begin
                    m_beat[c]++;
                end
            end
        end else begin
            m_gap[c]--;
        end
    endtask

    // One clock: compare at the falling edge, then drive inputs for the next rising edge.
    task automatic cycle(input int c, input logic v, input logic [3:0] d, input logic sr,
                         input logic ab, output logic [5:0] obs);
        @(negedge clk);
        obs = obs_of(c);
        chk($sformatf("cfg%0d outputs", c), {26'd0, obs}, {26'd0, m_exp(c)});
        iv[c]   = v;
        id[c]   = d;
        srdy[c] = sr;
        abt[c]  = ab;
        m_step(c, v, d, sr, ab);
    endtask

    // Offer one word, then run 16 cycles with a scripted ser_ready pattern and optional abort.
    task automatic send(input int c, input logic [3:0] d, input logic [15:0] srp, input int abc,
                        input int capi, output logic [3:0] bits, output logic [3:0] fsb,
                        output logic [3:0] flb, output int nb, output logic [5:0] cap0,
                        output logic [5:0] cap1);
        logic [5:0] o;
        bits = '0; fsb = '0; flb = '0; nb = 0; cap0 = '0; cap1 = '0;
        cycle(c, 1'b1, d, 1'b0, 1'b0, o);
        for (int i = 0; i < 16; i++) begin
            cycle(c, 1'b0, 4'h0, srp[i], (i == abc), o);
            if (i == capi)     cap0 = o;
            if (i == capi + 1) cap1 = o;
            if (o[3] && srp[i] && i != abc && nb < 4) begin
                bits[nb] = o[2];
                fsb[nb]  = o[1];
                flb[nb]  = o[0];
                nb++;
            end
        end
    endtask

    task automatic rand_run(input int c, input int n);
        logic       pend;
        logic [3:0] pd;
        logic       acc;
        logic [5:0] o;
        pend = 1'b0;
        pd   = 4'h0;
        for (int k = 0; k < n; k++) begin
            if (!pend && $urandom_range(2) == 0) begin
                pend = 1'b1;
                pd   = 4'($urandom);
            end
            acc = pend && !m_act[c] && m_gap[c] == 0;
            cycle(c, pend, pd, ($urandom_range(3) != 0), ($urandom_range(19) == 0), o);
            if (acc) pend = 1'b0;
        end
        for (int k = 0; k < 12; k++) cycle(c, 1'b0, 4'h0, 1'b1, 1'b0, o);
    endtask

    initial begin
        logic [3:0] b, fs, fl;
        logic [5:0] c0v, c1v, o;
        logic [9:0] svp, sop;
        int         nb;

        for (int c = 0; c < 3; c++) begin
            iv[c] = 1'b0; id[c] = 4'h0; srdy[c] = 1'b0; abt[c] = 1'b0;
        end
        m_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #7;
        for (int c = 0; c < 3; c++)
            chk($sformatf("cfg%0d reset state", c), {26'd0, obs_of(c)}, 32'b100000);
        #4 rst_n = 1'b1;

        // LSB-first 0011 -> 1,1,0,0 then one gap cycle then ready.
        send(0, 4'b0011, 16'hFFFF, -1, 4, b, fs, fl, nb, c0v, c1v);
        chk("lsb bits", {28'd0, b}, 32'b0011);
        chk("lsb beats", nb, 4);
        chk("lsb frame_start", {28'd0, fs}, 32'b0001);
        chk("lsb frame_last", {28'd0, fl}, 32'b1000);
        chk("gap cycle", {26'd0, c0v}, 32'b010000);
        chk("ready after gap", {26'd0, c1v}, 32'b100000);

        // Stall three cycles on beat 1 of 1100.
        send(0, 4'b1100, 16'hFFF1, -1, 2, b, fs, fl, nb, c0v, c1v);
        chk("stall bits", {28'd0, b}, 32'b1100);
        chk("stall beats", nb, 4);
        chk("stall hold a", {26'd0, c0v}, 32'b011000);
        chk("stall hold b", {26'd0, c1v}, 32'b011000);
        chk("stall frame_last", {28'd0, fl}, 32'b1000);

        // Abort on beat 2 of 1110, then a clean 0001.
        send(0, 4'b1110, 16'hFFFF, 2, 3, b, fs, fl, nb, c0v, c1v);
        chk("abort beats", nb, 2);
        chk("abort bits", {28'd0, b}, 32'b0010);
        chk("idle after abort", {26'd0, c0v}, 32'b100000);
        send(0, 4'b0001, 16'hFFFF, -1, 8, b, fs, fl, nb, c0v, c1v);
        chk("post-abort bits", {28'd0, b}, 32'b0001);
        chk("post-abort beats", nb, 4);

        // Asynchronous reset in the middle of a frame.
        cycle(0, 1'b1, 4'b1011, 1'b0, 1'b0, o);
        cycle(0, 1'b0, 4'h0, 1'b1, 1'b0, o);
        cycle(0, 1'b0, 4'h0, 1'b1, 1'b0, o);
        #2 rst_n = 1'b0;
        #1 chk("mid-frame reset", {26'd0, obs_of(0)}, 32'b100000);
        m_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;

        rand_run(0, 400);

        // MSB-first 0111 -> 0,1,1,1 with a two-cycle gap.
        send(1, 4'b0111, 16'hFFFF, -1, 4, b, fs, fl, nb, c0v, c1v);
        chk("msb bits", {28'd0, b}, 32'b1110);
        chk("msb gap 1", {26'd0, c0v}, 32'b010000);
        chk("msb gap 2", {26'd0, c1v}, 32'b010000);
        rand_run(1, 400);

        // Back-to-back 1010, 0101 with no gap: exactly one idle cycle between frames.
        cycle(2, 1'b1, 4'b1010, 1'b0, 1'b0, o);
        svp = '0;
        sop = '0;
        for (int i = 0; i < 10; i++) begin
            cycle(2, (i <= 4), 4'b0101, 1'b1, 1'b0, o);
            svp[i] = o[3];
            sop[i] = o[2];
        end
        chk("b2b ser_valid", {22'd0, svp}, 32'h1EF);
        chk("b2b ser_out", {22'd0, sop}, 32'h0AA);
        rand_run(2, 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_frame_ctrl.md
Name: piso_frame_ctrl

Overview:
Controller that sequences a parallel-in/serial-out shift datapath. It accepts a WIDTH-bit word over a valid/ready handshake, loads it, and shifts it out one bit per accepted serial beat. Bit order is configurable, the sink can stall output with ser_ready, and a programmable idle gap separates frames. It sits between a word producer and a serial sink and owns all load/shift sequencing.

Parameters:
WIDTH, 4, word width in bits (>=2)
LSB_FIRST, 1, 1 = bit 0 shifted first; 0 = bit WIDTH-1 first
GAP_CYCLES, 1, idle cycles forced after the last bit of a frame (0 allowed)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  parallel word offered
in_data  input  WIDTH  parallel word; must stay stable while in_valid && !in_ready
in_ready  output  1  controller can accept a word (combinational: state==IDLE)
ser_out  output  1  current serial bit
ser_valid  output  1  ser_out is a valid frame bit
ser_ready  input  1  sink accepts current bit this cycle
frame_start  output  1  high with the first bit of a frame
frame_last  output  1  high with the last bit of a frame
busy  output  1  state != IDLE
abort  input  1  synchronous flush to IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, shift register=0, bit counter=0, gap counter=0. Outputs: ser_out=0, ser_valid=0, frame_start=0, frame_last=0, busy=0, in_ready=1.
- States: IDLE, SHIFT, GAP.
- IDLE: in_ready=1, ser_valid=0. When in_valid && in_ready at an edge, in_data is captured, bit counter=0, next state SHIFT. Latency: the first bit is on ser_out in the cycle after the accept edge.
- SHIFT: ser_valid=1. ser_out = shreg[0] if LSB_FIRST, else shreg[WIDTH-1]. A beat completes on an edge with ser_valid && ser_ready. On each beat the register shifts toward the output end with 0 fill, and the counter increments.
  - If ser_ready is low, ser_out, the counter and the flags hold. Stalls are unbounded.
  - frame_start = (count==0). frame_last = (count==WIDTH-1).
- The beat with frame_last completes the frame: next state is GAP if GAP_CYCLES>0, otherwise IDLE.
- GAP: ser_valid=0 and in_ready=0. The gap counter counts GAP_CYCLES cycles, then the state returns to IDLE.
  - Minimum frame-to-frame spacing is WIDTH + GAP_CYCLES + 1 cycles, because IDLE lasts at least one cycle.
- abort (synchronous) forces state=IDLE on the next edge and clears the counters and shift register. It overrides a simultaneous handshake and is ignored when already in IDLE. If abort and in_valid arrive in IDLE on the same edge, the word is accepted.
- in_valid while busy: ignored (in_ready=0). The source holds the word.
- Counter width: $clog2(WIDTH). There is no wrap, because the counter is cleared on every load.
- Reset asserted mid-frame: outputs go to their reset values immediately, with no partial-frame completion.

Decomposition:
- Shared package/header piso_ctrl_pkg: state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2, and the function computing counter width.
- One sub-module: piso_shift_reg (WIDTH, LSB_FIRST). It has ports clk, rst_n, load, shift, clear, d, so. Load takes precedence over shift. The controller instantiates it and drives load/shift/clear.

Test Plan:
- Reset then idle (WIDTH=4, LSB_FIRST=1, GAP_CYCLES=1) -> in_ready=1, busy=0, ser_valid=0. Assert rst_n low mid-frame -> all outputs return to reset values in the same cycle.
- in_data=4'b0011, ser_ready=1 -> ser_out 1,1,0,0 on the 4 cycles after accept. frame_start on beat 0, frame_last on beat 3, then 1 gap cycle, then in_ready=1.
- Same stimulus with LSB_FIRST=0, in_data=4'b0111 -> ser_out 0,1,1,1.
- in_data=4'b1100, ser_ready low for 3 cycles during beat 1 -> ser_out holds 0 and frame_start/frame_last hold. The sequence resumes 0,0,1,1 with no lost or duplicated bit.
- Back-to-back words 4'b1010 then 4'b0101 with in_valid held high, GAP_CYCLES=0 -> frames separated by exactly 1 idle cycle, output 0,1,0,1,(gap),1,0,1,0.
- abort asserted at beat 2 of 4'b1110 -> next cycle state IDLE, ser_valid=0, in_ready=1. The next word 4'b0001 serializes cleanly as 1,0,0,0.
